// File: rtl/bip_pkg.sv
// Shared definitions for the BIP accumulator machine: opcodes, sequencer
// states, accumulator-mux and adder-function codes.
package bip_pkg;

  // Opcode field values (instr[15:11]); anything not listed runs as a NOP.
  localparam logic [4:0] OPC_HLT  = 5'b00000;
  localparam logic [4:0] OPC_STO  = 5'b00001;
  localparam logic [4:0] OPC_LD   = 5'b00010;
  localparam logic [4:0] OPC_LDI  = 5'b00011;
  localparam logic [4:0] OPC_ADD  = 5'b00100;
  localparam logic [4:0] OPC_ADDI = 5'b00101;
  localparam logic [4:0] OPC_SUB  = 5'b00110;
  localparam logic [4:0] OPC_SUBI = 5'b00111;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEMWB  = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  // Accumulator input mux codes.
  localparam logic [1:0] SEL_RAM = 2'b00;
  localparam logic [1:0] SEL_IMM = 2'b01;
  localparam logic [1:0] SEL_ALU = 2'b10;

  // Adder B operand select.
  localparam logic SELB_RAM = 1'b0;
  localparam logic SELB_IMM = 1'b1;

  // Adder function, shared with the arithmetic unit.
  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;

  // Bundle of control outputs produced by the sequencer each cycle.
  typedef struct packed {
    logic       wr_acc;
    logic       rd_ram;
    logic       wr_ram;
    logic       halted;
    logic [1:0] sel_a;
    logic       sel_b;
    logic       op;
  } ctrl_t;

endpackage

// File: rtl/bip_control_unit_if.sv
// Connection between the sequencer and the program ROM / data RAM /
// arithmetic unit. The master side is the control unit.
interface bip_control_unit_if #(
  parameter int PC_W    = 11,
  parameter int OPD_W   = 11,
  parameter int INSTR_W = 16
);
  logic               run;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    pc;
  logic [OPD_W-1:0]   operand;
  logic [1:0]         sel_a;
  logic               sel_b;
  logic               op;
  logic               wr_acc;
  logic               rd_ram;
  logic               wr_ram;
  logic               halted;

  modport master (
    input  run, instr,
    output pc, operand, sel_a, sel_b, op, wr_acc, rd_ram, wr_ram, halted
  );

  modport slave (
    output run, instr,
    input  pc, operand, sel_a, sel_b, op, wr_acc, rd_ram, wr_ram, halted
  );
endinterface

// File: rtl/bip_decoder.sv
// Pure opcode decoder. Reports what an instruction needs; the sequencer
// decides in which state each of these actually reaches the datapath.
module bip_decoder
  import bip_pkg::*;
#(
  parameter int OPC_W = 5
) (
  input  logic [OPC_W-1:0] opcode,
  output logic             is_halt,
  output logic             uses_ram_read,
  output logic             writes_acc,
  output logic             writes_ram,
  output logic             op,
  output logic [1:0]       sel_a,
  output logic             sel_b
);

  // Opcode to control-attribute lookup.
  always_comb begin
    // NOTE: every output gets a value before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    is_halt       = 1'b0;
    uses_ram_read = 1'b0;
    writes_acc    = 1'b0;
    writes_ram    = 1'b0;
    op            = OP_SUB;
    sel_a         = SEL_RAM;
    sel_b         = SELB_RAM;
    case (opcode)
      OPC_HLT: is_halt = 1'b1;
      OPC_STO: writes_ram = 1'b1;
      OPC_LD: begin
        uses_ram_read = 1'b1;
        writes_acc    = 1'b1;
        sel_a         = SEL_RAM;
      end
      OPC_LDI: begin
        writes_acc = 1'b1;
        sel_a      = SEL_IMM;
      end
      OPC_ADD: begin
        uses_ram_read = 1'b1;
        writes_acc    = 1'b1;
        sel_a         = SEL_ALU;
        sel_b         = SELB_RAM;
        op            = OP_ADD;
      end
      OPC_ADDI: begin
        writes_acc = 1'b1;
        sel_a      = SEL_ALU;
        sel_b      = SELB_IMM;
        op         = OP_ADD;
      end
      OPC_SUB: begin
        uses_ram_read = 1'b1;
        writes_acc    = 1'b1;
        sel_a         = SEL_ALU;
        sel_b         = SELB_RAM;
        op            = OP_SUB;
      end
      OPC_SUBI: begin
        writes_acc = 1'b1;
        sel_a      = SEL_ALU;
        sel_b      = SELB_IMM;
        op         = OP_SUB;
      end
      default: ; // unlisted opcodes behave as NOP
    endcase
  end

endmodule

// File: rtl/bip_control_unit.sv
// Multi-cycle sequencer for the BIP accumulator datapath. Owns the program
// counter and instruction register and produces Moore control strobes.
module bip_control_unit
  import bip_pkg::*;
#(
  parameter int PC_W  = 11,
  parameter int OPC_W = 5,
  parameter int OPD_W = 11
) (
  input  logic                clk,
  input  logic                reset,
  bip_control_unit_if.master  bus
);

  localparam int INSTR_W = OPC_W + OPD_W;

  state_t             r_state;
  state_t             w_next_state;
  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_ir;
  logic               w_pc_inc;
  logic [OPC_W-1:0]   w_opcode;
  ctrl_t              w_ctrl;

  logic               w_is_halt;
  logic               w_uses_ram_read;
  logic               w_writes_acc;
  logic               w_writes_ram;
  logic               w_op;
  logic [1:0]         w_sel_a;
  logic               w_sel_b;

  // In DECODE the fresh ROM word picks the next state; everywhere else the
  // latched opcode is decoded, so outputs never follow instr directly.
  assign w_opcode = (r_state == ST_DECODE) ? bus.instr[INSTR_W-1 -: OPC_W]
                                           : r_ir[INSTR_W-1 -: OPC_W];

  bip_decoder #(.OPC_W(OPC_W)) u_decoder (
    .opcode        (w_opcode),
    .is_halt       (w_is_halt),
    .uses_ram_read (w_uses_ram_read),
    .writes_acc    (w_writes_acc),
    .writes_ram    (w_writes_ram),
    .op            (w_op),
    .sel_a         (w_sel_a),
    .sel_b         (w_sel_b)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) r_state <= ST_FETCH;
    else       r_state <= w_next_state;
  end

  // Program counter and instruction register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= '0;
      r_ir <= '0;
    end else begin
      if (r_state == ST_DECODE) r_ir <= bus.instr;
      if (w_pc_inc)             r_pc <= r_pc + PC_W'(1);
    end
  end

  // Next-state logic; the PC advances only on an instruction's last cycle.
  always_comb begin
    w_next_state = r_state;
    w_pc_inc     = 1'b0;
    case (r_state)
      ST_FETCH:  if (bus.run) w_next_state = ST_DECODE;
      ST_DECODE: w_next_state = w_is_halt ? ST_HALT : ST_EXEC;
      ST_EXEC: begin
        if (w_uses_ram_read) begin
          w_next_state = ST_MEMWB;
        end else begin
          w_next_state = ST_FETCH;
          w_pc_inc     = 1'b1;
        end
      end
      ST_MEMWB: begin
        w_next_state = ST_FETCH;
        w_pc_inc     = 1'b1;
      end
      ST_HALT:  w_next_state = ST_HALT;
      default:  w_next_state = ST_FETCH;
    endcase
  end

  // Moore output decode; reset silences everything in the same cycle and
  // mux/function selects are only non-zero alongside an accumulator write.
  always_comb begin
    w_ctrl = '0;
    if (!reset) begin
      case (r_state)
        ST_EXEC: begin
          w_ctrl.rd_ram = w_uses_ram_read;
          w_ctrl.wr_ram = w_writes_ram;
          if (w_writes_acc && !w_uses_ram_read) begin
            w_ctrl.wr_acc = 1'b1;
            w_ctrl.sel_a  = w_sel_a;
            w_ctrl.sel_b  = w_sel_b;
            w_ctrl.op     = w_op;
          end
        end
        ST_MEMWB: begin
          w_ctrl.wr_acc = 1'b1;
          w_ctrl.sel_a  = w_sel_a;
          w_ctrl.sel_b  = w_sel_b;
          w_ctrl.op     = w_op;
        end
        ST_HALT: w_ctrl.halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.pc      = r_pc;
  assign bus.operand = r_ir[OPD_W-1:0];
  assign bus.sel_a   = w_ctrl.sel_a;
  assign bus.sel_b   = w_ctrl.sel_b;
  assign bus.op      = w_ctrl.op;
  assign bus.wr_acc  = w_ctrl.wr_acc;
  assign bus.rd_ram  = w_ctrl.rd_ram;
  assign bus.wr_ram  = w_ctrl.wr_ram;
  assign bus.halted  = w_ctrl.halted;

endmodule
